// File: rtl/ysyx_lsu_pkg.sv
// Shared load/store encodings and FSM states for the LSU and the decoder that feeds it.
// Strobe/lane helpers keep the top-level FSM free of bit fiddling.
package ysyx_lsu_pkg;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_B    = 3'b001;
  localparam logic [2:0] LD_BU   = 3'b010;
  localparam logic [2:0] LD_H    = 3'b011;
  localparam logic [2:0] LD_HU   = 3'b100;
  localparam logic [2:0] LD_W    = 3'b101;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_W    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] store_strb(input logic [1:0] wr_sel, input logic [1:0] off);
    case (wr_sel)
      ST_B:    store_strb = 4'b0001 << off;
      ST_H:    store_strb = 4'b0011 << off;
      ST_W:    store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] wr_sel, input logic [31:0] wdata);
    case (wr_sel)
      ST_B:    store_data = {4{wdata[7:0]}};
      ST_H:    store_data = {2{wdata[15:0]}};
      ST_W:    store_data = wdata;
      default: store_data = 32'h0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] rd_sel, input logic [1:0] wr_sel);
    is_illegal = ((rd_sel != LD_NONE) && (wr_sel != ST_NONE)) || (rd_sel > LD_W);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] rd_sel, input logic [1:0] wr_sel,
                                         input logic [1:0] off);
    logic half, word;
    half = (rd_sel == LD_H) || (rd_sel == LD_HU) || (wr_sel == ST_H);
    word = (rd_sel == LD_W) || (wr_sel == ST_W);
    is_misaligned = (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_lsu_ext.sv
// Load extraction: selects the addressed byte/half/word from a bus word and extends it.
// Returns 0 for LD_NONE so store responses come back with clean rdata.
module ysyx_lsu_ext
  import ysyx_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  dm_rd_sel,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (dm_rd_sel)
      LD_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      LD_BU:   result = {24'h0, shifted[7:0]};
      LD_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      LD_HU:   result = {16'h0, shifted[15:0]};
      LD_W:    result = shifted;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Multi-cycle load/store unit: one outstanding access over a req/gnt/rvalid data bus,
// with a valid/ready result port toward writeback.
//
// state | meaning
// IDLE  | ready for a new access; decode errors and no-ops go straight to RESP
// REQ   | mem_req held with stable fields until mem_gnt
// WAIT  | waiting for mem_rvalid, abandoned with err after TIMEOUT cycles
// RESP  | out_valid with rdata/err held until out_ready
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  dm_rd_sel,
  input  logic [1:0]  dm_wr_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e       state;
  logic [2:0]       op_rd;
  logic [1:0]       op_off;
  logic [TO_W-1:0]  cnt;
  logic [31:0]      ext_data;

  assign in_ready = (state == IDLE);

  ysyx_lsu_ext u_ext (
    .word      (mem_rdata),
    .offset    (op_off),
    .dm_rd_sel (op_rd),
    .result    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_rd     <= LD_NONE;
      op_off    <= 2'b00;
      cnt       <= '0;
      out_valid <= 1'b0;
      rdata     <= 32'h0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_rd  <= dm_rd_sel;
            op_off <= addr[1:0];
            if ((dm_rd_sel == LD_NONE) && (dm_wr_sel == ST_NONE)) begin
              state     <= RESP;
              out_valid <= 1'b1;
              rdata     <= 32'h0;
              err       <= 1'b0;
            end else if (is_illegal(dm_rd_sel, dm_wr_sel) ||
                         is_misaligned(dm_rd_sel, dm_wr_sel, addr[1:0])) begin
              state     <= RESP;
              out_valid <= 1'b1;
              rdata     <= 32'h0;
              err       <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= (dm_wr_sel != ST_NONE);
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= store_strb(dm_wr_sel, addr[1:0]);
              mem_wdata <= store_data(dm_wr_sel, wdata);
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            state     <= WAIT;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            cnt       <= '0;
          end
        end
        WAIT: begin
          // A response landing on the last allowed cycle beats the timeout.
          if (mem_rvalid) begin
            state     <= RESP;
            out_valid <= 1'b1;
            rdata     <= ext_data;
            err       <= 1'b0;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            state     <= RESP;
            out_valid <= 1'b1;
            rdata     <= 32'h0;
            err       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed bench for ysyx_lsu with a small bus responder whose grant/response delays are set per test.
module tb_ysyx_lsu;
  import ysyx_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  dm_rd_sel;
  logic [1:0]  dm_wr_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  int   gnt_delay = 0;
  int   rv_delay = 0;
  logic force_rvalid = 1'b0;
  int   req_age = 0;
  int   wait_age = 0;
  logic waiting = 1'b0;

  int          r_lat, r_reqn;
  logic        r_stable, r_err, q_we;
  logic [31:0] r_data, q_addr, q_wdata;
  logic [3:0]  q_strb;

  ysyx_lsu #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dm_rd_sel(dm_rd_sel), .dm_wr_sel(dm_wr_sel), .addr(addr), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Bus responder: grants after gnt_delay request cycles, answers rv_delay cycles into WAIT.
  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_rvalid || out_valid || rst) waiting = 1'b0;
      if (mem_gnt && !rst) begin
        waiting = 1'b1;
        wait_age = 0;
      end
      req_age = mem_req ? req_age + 1 : 0;
      mem_gnt = mem_req && (req_age > gnt_delay);
      if (waiting) wait_age++;
      mem_rvalid = force_rvalid || (waiting && rv_delay >= 0 && wait_age > rv_delay);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_access(input logic [2:0] rd, input logic [1:0] wr,
                           input logic [31:0] a, input logic [31:0] d);
    dm_rd_sel = rd;
    dm_wr_sel = wr;
    addr = a;
    wdata = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = 1;
    r_reqn = 0;
    r_stable = 1'b1;
    q_addr = 32'h0; q_wdata = 32'h0; q_strb = 4'h0; q_we = 1'b0;
    while (1) begin
      if (mem_req) begin
        if (r_reqn == 0) begin
          q_addr = mem_addr; q_wdata = mem_wdata; q_strb = mem_wstrb; q_we = mem_we;
        end else if (q_addr !== mem_addr || q_wdata !== mem_wdata ||
                     q_strb !== mem_wstrb || q_we !== mem_we) begin
          r_stable = 1'b0;
        end
        r_reqn++;
      end
      if (out_valid || r_lat >= 60) break;
      @(posedge clk); #1;
      r_lat++;
    end
    if (!out_valid) r_lat = -1;
    r_data = rdata;
    r_err = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    dm_rd_sel = LD_NONE; dm_wr_sel = ST_NONE; addr = 32'h0; wdata = 32'h0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_wstrb !== 4'b0) begin failures++; $display("FAIL reset_mem_wstrb: got %b want 0000", mem_wstrb); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [2:0]  rds[6]  = '{LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_B};
    logic [31:0] adrs[6] = '{32'h80000003, 32'h80000003, 32'h80000002, 32'h80000000,
                             32'h80000000, 32'h80000001};
    logic [31:0] exps[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234,
                             32'h80FF1234, 32'h00000012};
    gnt_delay = 0; rv_delay = 0;
    mem_rdata = 32'h80FF1234;
    for (int i = 0; i < 6; i++) begin
      do_access(rds[i], ST_NONE, adrs[i], 32'h0);
      checks++; if (r_data !== exps[i]) begin failures++; $display("FAIL load_rdata[%0d]: got %h want %h", i, r_data, exps[i]); end
      checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL load_err[%0d]: got %b want 0", i, r_err); end
      checks++; if (r_lat !== 3) begin failures++; $display("FAIL load_latency[%0d]: got %0d want 3", i, r_lat); end
      checks++; if (q_addr !== {adrs[i][31:2], 2'b00} || q_we !== 1'b0 || q_strb !== 4'b0000) begin
        failures++; $display("FAIL load_bus[%0d]: got addr %h we %b strb %b", i, q_addr, q_we, q_strb);
      end
    end
  endtask

  task automatic test_stores();
    logic [1:0]  wrs[3]  = '{ST_H, ST_B, ST_W};
    logic [31:0] adrs[3] = '{32'h80000002, 32'h80000001, 32'h80000004};
    logic [31:0] wds[3]  = '{32'h0000ABCD, 32'h000000EE, 32'hDEADBEEF};
    logic [3:0]  strbs[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] lanes[3] = '{32'hABCDABCD, 32'hEEEEEEEE, 32'hDEADBEEF};
    logic [31:0] wadr[3]  = '{32'h80000000, 32'h80000000, 32'h80000004};
    gnt_delay = 0; rv_delay = 0;
    mem_rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      do_access(LD_NONE, wrs[i], adrs[i], wds[i]);
      checks++; if (q_strb !== strbs[i]) begin failures++; $display("FAIL store_wstrb[%0d]: got %b want %b", i, q_strb, strbs[i]); end
      checks++; if (q_wdata !== lanes[i]) begin failures++; $display("FAIL store_wdata[%0d]: got %h want %h", i, q_wdata, lanes[i]); end
      checks++; if (q_addr !== wadr[i] || q_we !== 1'b1) begin failures++; $display("FAIL store_addr_we[%0d]: got %h/%b want %h/1", i, q_addr, q_we, wadr[i]); end
      checks++; if (r_data !== 32'h0 || r_err !== 1'b0) begin failures++; $display("FAIL store_resp[%0d]: got %h/%b want 0/0", i, r_data, r_err); end
    end
  endtask

  task automatic test_delays();
    gnt_delay = 3; rv_delay = 2;
    mem_rdata = 32'hCAFEF00D;
    do_access(LD_W, ST_NONE, 32'h80000010, 32'h0);
    checks++; if (r_reqn !== 4) begin failures++; $display("FAIL delay_req_cycles: got %0d want 4", r_reqn); end
    checks++; if (r_stable !== 1'b1) begin failures++; $display("FAIL delay_req_stable: got %b want 1", r_stable); end
    checks++; if (r_lat !== 8) begin failures++; $display("FAIL delay_latency: got %0d want 8", r_lat); end
    checks++; if (r_data !== 32'hCAFEF00D || r_err !== 1'b0) begin failures++; $display("FAIL delay_rdata: got %h/%b want cafef00d/0", r_data, r_err); end
    gnt_delay = 0; rv_delay = 0;
  endtask

  task automatic test_errors();
    logic [2:0]  rds[6]  = '{LD_W, LD_W, 3'b110, LD_H, LD_NONE, LD_NONE};
    logic [1:0]  wrs[6]  = '{ST_NONE, ST_W, ST_NONE, ST_NONE, ST_H, ST_NONE};
    logic [31:0] adrs[6] = '{32'h80000001, 32'h80000000, 32'h80000000, 32'h80000003,
                             32'h80000005, 32'h80000000};
    logic        errs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      do_access(rds[i], wrs[i], adrs[i], 32'h12345678);
      checks++; if (r_err !== errs[i]) begin failures++; $display("FAIL error_flag[%0d]: got %b want %b", i, r_err, errs[i]); end
      checks++; if (r_lat !== 1 || r_reqn !== 0) begin failures++; $display("FAIL error_fast[%0d]: got lat %0d req %0d want 1/0", i, r_lat, r_reqn); end
      checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL error_rdata[%0d]: got %h want 0", i, r_data); end
    end
  endtask

  task automatic test_timeout();
    gnt_delay = 0; rv_delay = -1;
    mem_rdata = 32'h11112222;
    do_access(LD_W, ST_NONE, 32'h80000008, 32'h0);
    checks++; if (r_err !== 1'b1 || r_data !== 32'h0) begin failures++; $display("FAIL timeout_err: got %b/%h want 1/0", r_err, r_data); end
    checks++; if (r_lat !== 6) begin failures++; $display("FAIL timeout_latency: got %0d want 6", r_lat); end
    rv_delay = 3;
    do_access(LD_W, ST_NONE, 32'h80000008, 32'h0);
    checks++; if (r_err !== 1'b0 || r_data !== 32'h11112222) begin failures++; $display("FAIL timeout_edge_rvalid: got %b/%h want 0/11112222", r_err, r_data); end
    checks++; if (r_lat !== 6) begin failures++; $display("FAIL timeout_edge_latency: got %0d want 6", r_lat); end
    rv_delay = 0;
  endtask

  task automatic test_backpressure();
    gnt_delay = 0; rv_delay = 0;
    mem_rdata = 32'hBEEF0000;
    out_ready = 1'b0;
    do_access(LD_HU, ST_NONE, 32'h80000022, 32'h0);
    checks++; if (r_data !== 32'h0000BEEF) begin failures++; $display("FAIL bp_rdata: got %h want 0000beef", r_data); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rdata !== 32'h0000BEEF || err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid %b ready %b rdata %h err %b want 1/0/0000beef/0", i, out_valid, in_ready, rdata, err);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got valid %b ready %b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_in_wait();
    gnt_delay = 0; rv_delay = -1;
    mem_rdata = 32'hA5A5A5A5;
    dm_rd_sel = LD_W; dm_wr_sel = ST_NONE; addr = 32'h80000030; wdata = 32'h0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_wait_precond: got req %b valid %b ready %b want 0/0/0", mem_req, out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_idle: got ready %b valid %b want 1/0", in_ready, out_valid); end
    force_rvalid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    force_rvalid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
      failures++; $display("FAIL rst_late_rvalid: got valid %b ready %b req %b want 0/1/0", out_valid, in_ready, mem_req);
    end
    rv_delay = 0;
    mem_rdata = 32'h0BADF00D;
    do_access(LD_W, ST_NONE, 32'h80000030, 32'h0);
    checks++; if (r_data !== 32'h0BADF00D || r_err !== 1'b0 || r_lat !== 3) begin
      failures++; $display("FAIL rst_recover: got %h/%b lat %0d want 0badf00d/0 lat 3", r_data, r_err, r_lat);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_delays();
    test_errors();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
